// File: rtl/multi_sync_filter_pkg.sv
// Shared types and helpers for the multi-channel synchronizer / glitch filter.
// Latency: n/a (types and elaboration-time helpers only).
// Backpressure: n/a.
package multi_sync_filter_pkg;

  // Per-channel filter state: STABLE while sync agrees with clean,
  // COUNTING while a disagreement is being timed.
  typedef enum logic [0:0] {
    FILT_STABLE   = 1'b0,
    FILT_COUNTING = 1'b1
  } filt_state_t;

  // Shallower chains do not give metastability time to resolve.
  localparam int MIN_STAGES = 2;

  // Counter width for a filter of FILTER_CYCLES. A bypassed filter
  // (0 cycles) has no counter; a minimum width of 1 keeps the
  // declarations legal.
  function automatic int cnt_width(input int filter_cycles);
    return (filter_cycles > 0) ? $clog2(filter_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/multi_sync_filter_chan.sv
// One channel: flop synchronizer, optional stability filter, rise/fall pulses.
// Latency: sync after STAGES-1 edges past sampling, clean FILTER_CYCLES edges later.
// Backpressure: none; free-running, every edge advances the pipeline.
//
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   async_signal  raw input from another domain / a pin
//   sync_signal   last synchronizer flop (unfiltered)
//   clean_signal  filtered level
//   rise_pulse    one cycle high when clean goes 0->1
//   fall_pulse    one cycle high when clean goes 1->0
module sync_filter_chan
  import multi_sync_filter_pkg::*;
#(
  parameter int   STAGES        = 2,
  parameter int   FILTER_CYCLES = 0,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_signal,
  output logic sync_signal,
  output logic clean_signal,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int CNT_W = cnt_width(FILTER_CYCLES);

  if (STAGES < MIN_STAGES) begin : g_bad_stages
    $error("sync_filter_chan: STAGES must be >= 2");
  end

  // Synchronizer chain; bit 0 is the flop that may go metastable.
  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], async_signal};
    end
  end

  assign sync_signal = chain[STAGES-1];

  if (FILTER_CYCLES == 0) begin : g_bypass
    assign clean_signal = sync_signal;
  end else begin : g_filter
    // Value the counter holds on the edge just before the flip.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    filt_state_t      state;
    filt_state_t      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             clean_q;
    logic             clean_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state   <= FILT_STABLE;
        cnt     <= '0;
        clean_q <= RESET_VAL;
      end else begin
        state   <= state_nxt;
        cnt     <= cnt_nxt;
        clean_q <= clean_nxt;
      end
    end

    // The counter tops out at FILTER_CYCLES-1 and is cleared on the
    // flip, so it can never wrap.
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      clean_nxt = clean_q;
      case (state)
        FILT_STABLE: begin
          cnt_nxt = '0;
          if (sync_signal != clean_q) begin
            if (CNT_LAST == '0) begin
              // Single-cycle filter: first disagreeing edge already qualifies.
              clean_nxt = sync_signal;
            end else begin
              state_nxt = FILT_COUNTING;
              cnt_nxt   = CNT_W'(1);
            end
          end
        end
        FILT_COUNTING: begin
          if (sync_signal == clean_q) begin
            // Glitch rejected: input came back before qualifying.
            state_nxt = FILT_STABLE;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = FILT_STABLE;
            cnt_nxt   = '0;
            clean_nxt = sync_signal;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = FILT_STABLE;
          cnt_nxt   = '0;
        end
      endcase
    end

    assign clean_signal = clean_q;
  end

  // prev resets to the same value as clean, so reset release never
  // manufactures an edge.
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= RESET_VAL;
    end else begin
      prev <= clean_signal;
    end
  end

  assign rise_pulse = clean_signal & ~prev;
  assign fall_pulse = ~clean_signal & prev;

endmodule

// File: rtl/multi_sync_filter.sv
// WIDTH independent CDC front-end channels (sync, glitch filter, edge pulses).
// Latency: sync STAGES-1 edges after sampling, clean/pulses FILTER_CYCLES later.
// Backpressure: none; outputs are levels and single-cycle pulses.
//
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   async_signal  [WIDTH] raw inputs
//   sync_signal   [WIDTH] synchronized, unfiltered
//   clean_signal  [WIDTH] filtered levels
//   rise_pulse    [WIDTH] clean 0->1 pulses
//   fall_pulse    [WIDTH] clean 1->0 pulses
//   any_change    OR of all rise and fall pulses
module multi_sync_filter #(
  parameter int               WIDTH         = 1,
  parameter int               STAGES        = 2,
  parameter int               FILTER_CYCLES = 0,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_signal,
  output logic [WIDTH-1:0] sync_signal,
  output logic [WIDTH-1:0] clean_signal,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             any_change
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    sync_filter_chan #(
      .STAGES        (STAGES),
      .FILTER_CYCLES (FILTER_CYCLES),
      .RESET_VAL     (RESET_VAL[i])
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .async_signal (async_signal[i]),
      .sync_signal  (sync_signal[i]),
      .clean_signal (clean_signal[i]),
      .rise_pulse   (rise_pulse[i]),
      .fall_pulse   (fall_pulse[i])
    );
  end

  assign any_change = |(rise_pulse | fall_pulse);

endmodule

// File: tb/tb_multi_sync_filter.sv
// Bench for multi_sync_filter: directed table, hand sequences, random vs model.
// Instances: A (S=2,F=4,RV=0), B (S=2,F=0,RV=0), C (S=3,F=2,RV=F).
// All share clock, reset and inputs; outputs sampled on the falling edge.
module tb_multi_sync_filter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] async_sig;

  logic [3:0] sync_a, clean_a, rise_a, fall_a;
  logic [3:0] sync_b, clean_b, rise_b, fall_b;
  logic [3:0] sync_c, clean_c, rise_c, fall_c;
  logic       any_a, any_b, any_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_sync_filter #(.WIDTH(4), .STAGES(2), .FILTER_CYCLES(4), .RESET_VAL(4'h0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .async_signal(async_sig), .sync_signal(sync_a),
    .clean_signal(clean_a), .rise_pulse(rise_a), .fall_pulse(fall_a), .any_change(any_a));

  multi_sync_filter #(.WIDTH(4), .STAGES(2), .FILTER_CYCLES(0), .RESET_VAL(4'h0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .async_signal(async_sig), .sync_signal(sync_b),
    .clean_signal(clean_b), .rise_pulse(rise_b), .fall_pulse(fall_b), .any_change(any_b));

  multi_sync_filter #(.WIDTH(4), .STAGES(3), .FILTER_CYCLES(2), .RESET_VAL(4'hF)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .async_signal(async_sig), .sync_signal(sync_c),
    .clean_signal(clean_c), .rise_pulse(rise_c), .fall_pulse(fall_c), .any_change(any_c));

  // ---------------- reference model ----------------
  // sync  : the input sampled STAGES-1 edges ago (RESET_VAL until enough
  //         post-reset samples exist).
  // clean : flips once the last F pre-edge sync values all disagree with it.
  int         p_s [3] = '{2, 2, 3};
  int         p_f [3] = '{4, 0, 2};
  logic [3:0] p_rv[3] = '{4'h0, 4'h0, 4'hF};

  logic [3:0] ahist[3][8];
  logic [3:0] win  [3][8];
  int         an[3];
  int         wn[3];
  logic [3:0] m_sync[3], m_clean[3], m_prev[3];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      an[i] = 0;
      wn[i] = 0;
      m_sync[i]  = p_rv[i];
      m_clean[i] = p_rv[i];
      m_prev[i]  = p_rv[i];
    end
  endtask

  task automatic model_step(input int i);
    logic [3:0] pre;
    logic       all_diff;
    pre = m_sync[i];
    for (int k = 7; k > 0; k--) ahist[i][k] = ahist[i][k-1];
    ahist[i][0] = async_sig;
    if (an[i] < 8) an[i]++;
    m_sync[i] = (an[i] >= p_s[i]) ? ahist[i][p_s[i]-1] : p_rv[i];
    for (int k = 7; k > 0; k--) win[i][k] = win[i][k-1];
    win[i][0] = pre;
    if (wn[i] < 8) wn[i]++;
    m_prev[i] = m_clean[i];
    if (p_f[i] == 0) begin
      m_clean[i] = m_sync[i];
    end else if (wn[i] >= p_f[i]) begin
      for (int c = 0; c < 4; c++) begin
        all_diff = 1'b1;
        for (int k = 0; k < p_f[i]; k++)
          if (win[i][k][c] == m_clean[i][c]) all_diff = 1'b0;
        if (all_diff) m_clean[i][c] = ~m_clean[i][c];
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else for (int i = 0; i < 3; i++) model_step(i);
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_inst(input int i, input logic [3:0] s, input logic [3:0] c,
                          input logic [3:0] r, input logic [3:0] f, input logic a);
    logic [3:0] er, ef;
    er = m_clean[i] & ~m_prev[i];
    ef = ~m_clean[i] & m_prev[i];
    chk($sformatf("inst%0d sync", i),  s, m_sync[i]);
    chk($sformatf("inst%0d clean", i), c, m_clean[i]);
    chk($sformatf("inst%0d rise", i),  r, er);
    chk($sformatf("inst%0d fall", i),  f, ef);
    chk($sformatf("inst%0d any", i),   {3'b0, a}, {3'b0, |(er | ef)});
  endtask

  task automatic check_model();
    chk_inst(0, sync_a, clean_a, rise_a, fall_a, any_a);
    chk_inst(1, sync_b, clean_b, rise_b, fall_b, any_b);
    chk_inst(2, sync_c, clean_c, rise_c, fall_c, any_c);
  endtask

  // ---------------- directed table for instance A ----------------
  typedef struct {
    logic [3:0] a;
    logic [3:0] s;
    logic [3:0] c;
    logic [3:0] r;
    logic [3:0] f;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] a, input logic [3:0] s, input logic [3:0] c,
                     input logic [3:0] r, input logic [3:0] f);
    vec_t v;
    v.a = a; v.s = s; v.c = c; v.r = r; v.f = f;
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int rate;
    int rst_hold;

    // Row k: drive a, one rising edge, then expect (sync, clean, rise, fall).
    // ch0 step up then down: sync one edge late, clean four more.
    add(4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
    add(4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
    add(4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
    add(4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
    add(4'h1, 4'h1, 4'h1, 4'h1, 4'h0);
    add(4'h1, 4'h1, 4'h1, 4'h0, 4'h0);
    add(4'h0, 4'h1, 4'h1, 4'h0, 4'h0);
    add(4'h0, 4'h0, 4'h1, 4'h0, 4'h0);
    add(4'h0, 4'h0, 4'h1, 4'h0, 4'h0);
    add(4'h0, 4'h0, 4'h1, 4'h0, 4'h0);
    add(4'h0, 4'h0, 4'h1, 4'h0, 4'h0);
    add(4'h0, 4'h0, 4'h0, 4'h0, 4'h1);
    add(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    // ch2 glitch: three cycles high is rejected.
    add(4'h4, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'h4, 4'h4, 4'h0, 4'h0, 4'h0);
    add(4'h4, 4'h4, 4'h0, 4'h0, 4'h0);
    add(4'h0, 4'h4, 4'h0, 4'h0, 4'h0);
    add(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    // ch1 high for exactly four cycles: just qualifies.
    add(4'h2, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'h2, 4'h2, 4'h0, 4'h0, 4'h0);
    add(4'h2, 4'h2, 4'h0, 4'h0, 4'h0);
    add(4'h2, 4'h2, 4'h0, 4'h0, 4'h0);
    add(4'h0, 4'h2, 4'h0, 4'h0, 4'h0);
    add(4'h0, 4'h0, 4'h2, 4'h2, 4'h0);
    add(4'h0, 4'h0, 4'h2, 4'h0, 4'h0);
    add(4'h0, 4'h0, 4'h2, 4'h0, 4'h0);
    add(4'h0, 4'h0, 4'h2, 4'h0, 4'h0);
    add(4'h0, 4'h0, 4'h0, 4'h0, 4'h2);
    add(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    // ch3 preset high, then ch1 rises and ch3 falls together.
    add(4'h8, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'h8, 4'h8, 4'h0, 4'h0, 4'h0);
    add(4'h8, 4'h8, 4'h0, 4'h0, 4'h0);
    add(4'h8, 4'h8, 4'h0, 4'h0, 4'h0);
    add(4'h8, 4'h8, 4'h0, 4'h0, 4'h0);
    add(4'h8, 4'h8, 4'h8, 4'h8, 4'h0);
    add(4'h2, 4'h8, 4'h8, 4'h0, 4'h0);
    add(4'h2, 4'h2, 4'h8, 4'h0, 4'h0);
    add(4'h2, 4'h2, 4'h8, 4'h0, 4'h0);
    add(4'h2, 4'h2, 4'h8, 4'h0, 4'h0);
    add(4'h2, 4'h2, 4'h8, 4'h0, 4'h0);
    add(4'h2, 4'h2, 4'h2, 4'h2, 4'h8);
    add(4'h2, 4'h2, 4'h2, 4'h0, 4'h0);

    // 1. Reset held with inputs high.
    rst_n = 1'b0;
    async_sig = 4'hF;
    repeat (5) begin
      @(negedge clk);
      chk("rst sync_a", sync_a, 4'h0);
      chk("rst clean_a", clean_a, 4'h0);
      chk("rst pulses_a", rise_a | fall_a, 4'h0);
      chk("rst sync_b", sync_b, 4'h0);
      chk("rst clean_c", clean_c, 4'hF);
      chk("rst any", {1'b0, any_a, any_b, any_c}, 4'h0);
      check_model();
    end
    async_sig = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check_model();
    end

    // 2-4. Directed table on instance A.
    for (int i = 0; i < tbl.size(); i++) begin
      async_sig = tbl[i].a;
      @(negedge clk);
      chk($sformatf("tbl[%0d] sync", i),  sync_a,  tbl[i].s);
      chk($sformatf("tbl[%0d] clean", i), clean_a, tbl[i].c);
      chk($sformatf("tbl[%0d] rise", i),  rise_a,  tbl[i].r);
      chk($sformatf("tbl[%0d] fall", i),  fall_a,  tbl[i].f);
      chk($sformatf("tbl[%0d] any", i), {3'b0, any_a}, {3'b0, |(tbl[i].r | tbl[i].f)});
      check_model();
    end

    // 6. Unfiltered build: sync, clean and rise together one edge late.
    async_sig = 4'h0;
    repeat (6) begin
      @(negedge clk);
      check_model();
    end
    async_sig = 4'h2;
    @(negedge clk);
    chk("b step sync early", sync_b, 4'h0);
    check_model();
    @(negedge clk);
    chk("b step sync", sync_b, 4'h2);
    chk("b step clean", clean_b, 4'h2);
    chk("b step rise", rise_b, 4'h2);
    check_model();
    @(negedge clk);
    chk("b step rise drop", rise_b, 4'h0);
    check_model();

    // 5. Reset mid-count, applied asynchronously mid-cycle.
    async_sig = 4'h0;
    repeat (8) begin
      @(negedge clk);
      check_model();
    end
    async_sig = 4'h1;
    @(negedge clk);
    check_model();
    @(negedge clk);
    chk("midrst sync up", sync_a, 4'h1);
    check_model();
    repeat (2) begin
      @(negedge clk);
      check_model();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("async clr sync_a", sync_a, 4'h0);
    chk("async clr clean_a", clean_a, 4'h0);
    chk("async clr sync_b", sync_b, 4'h0);
    chk("async clr sync_c", sync_c, 4'hF);
    @(negedge clk);
    async_sig = 4'h0;
    repeat (2) begin
      @(negedge clk);
      check_model();
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("midrst clean_a", clean_a, 4'h0);
      chk("midrst pulses_a", rise_a | fall_a, 4'h0);
      check_model();
    end

    // RESET_VAL=F build released with inputs high: no fall.
    rst_n = 1'b0;
    async_sig = 4'hF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("rvF no fall", fall_c, 4'h0);
      chk("rvF clean", clean_c, 4'hF);
      check_model();
    end

    // Random inputs at varying toggle rates with occasional resets.
    rate = 1;
    rst_hold = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      check_model();
      if (n % 200 == 0) rate = $urandom_range(1, 7);
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst_n = 1'b1;
      end else if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        rst_hold = $urandom_range(1, 3);
      end
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, rate) == 0) async_sig[c] = ~async_sig[c];
    end
    @(negedge clk);
    check_model();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
